rr_arbiter4: RTL and testbench

RR_ARBITER4 -- requirements
Module: rr_arbiter4

---
 rtl/rr_arbiter4.sv | 102 ++++++++++
 tb/tb_rr_arbiter4.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// ---------------------------------------------------------------------------
// rr_arbiter4 : 4-way round-robin arbiter with per-owner hold limit
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic [1:0] GNT_IDX,
  output logic       GNT_VLD
);

  localparam logic       ST_IDLE  = 1'b0;
  localparam logic       ST_GRANT = 1'b1;
  localparam logic [7:0] C_MAX    = 8'(MAX_HOLD);

  logic       state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [1:0] idx_q, idx_d;
  logic       vld_q, vld_d;
  logic [3:0] gnt_q, gnt_d;
  logic [2:0] pick;
  logic [1:0] search_start;

  // Returns {found, index} of the first requester at or after start (mod 4).
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] j;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      j = start + 2'(k);
      if (req[j]) res = {1'b1, j};
    end
    return res;
  endfunction

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    hcnt_d       = hcnt_q;
    idx_d        = idx_q;
    vld_d        = vld_q;
    search_start = (state_q == ST_IDLE) ? ptr_q : idx_q + 2'd1;
    pick         = rr_pick(REQ, search_start);

    if (state_q == ST_IDLE) begin
      if (pick[2]) begin
        state_d = ST_GRANT;
        idx_d   = pick[1:0];
        vld_d   = 1'b1;
        hcnt_d  = 8'd1;
      end
    end else if (REQ[idx_q] && (hcnt_q < C_MAX)) begin
      hcnt_d = hcnt_q + 8'd1;
    end else begin
      // Release: the owner is searched last, so it only wins back when alone.
      ptr_d = idx_q + 2'd1;
      if (pick[2]) begin
        idx_d  = pick[1:0];
        hcnt_d = 8'd1;
      end else begin
        state_d = ST_IDLE;
        idx_d   = 2'd0;
        vld_d   = 1'b0;
        hcnt_d  = 8'd0;
      end
    end

    gnt_d = vld_d ? (4'b0001 << idx_d) : 4'b0000;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      hcnt_q  <= 8'd0;
      idx_q   <= 2'd0;
      vld_q   <= 1'b0;
      gnt_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      gnt_q   <= gnt_d;
    end
  end

  assign GNT     = gnt_q;
  assign GNT_IDX = idx_q;
  assign GNT_VLD = vld_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter4 : vectors, corner sequences and random run vs. reference model
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rr_arbiter4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] REQ = 4'b0000;
  logic [3:0] gnt0, gnt1;
  logic [1:0] idx0, idx1;
  logic       vld0, vld1;

  int checks = 0;
  int errors = 0;

  rr_arbiter4 #(.MAX_HOLD(8)) u_dut0 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .GNT(gnt0), .GNT_IDX(idx0), .GNT_VLD(vld0)
  );
  rr_arbiter4 #(.MAX_HOLD(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .GNT(gnt1), .GNT_IDX(idx1), .GNT_VLD(vld1)
  );

  always #5 CLK = ~CLK;

  // Reference model: owner, hold count and rotation start per instance.
  int m_vld[2], m_own[2], m_ptr[2], m_hcnt[2];
  int m_max[2] = '{8, 1};

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      m_vld[d] = 0; m_own[d] = 0; m_ptr[d] = 0; m_hcnt[d] = 0;
    end
  endtask

  task automatic mstep(input logic [3:0] req);
    for (int d = 0; d < 2; d++) begin
      int start;
      int winner;
      if (m_vld[d] != 0 && req[m_own[d]] && m_hcnt[d] < m_max[d]) begin
        m_hcnt[d]++;
      end else begin
        if (m_vld[d] != 0) m_ptr[d] = (m_own[d] + 1) % 4;
        start  = m_ptr[d];
        winner = -1;
        for (int k = 0; k < 4; k++)
          if (winner < 0 && req[(start + k) % 4]) winner = (start + k) % 4;
        if (winner >= 0) begin
          m_vld[d] = 1; m_own[d] = winner; m_hcnt[d] = 1;
        end else begin
          m_vld[d] = 0; m_own[d] = 0; m_hcnt[d] = 0;
        end
      end
    end
  endtask

  function automatic int m_gnt(input int d);
    return (m_vld[d] != 0) ? (1 << m_own[d]) : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_inv();
    int dec0, dec1;
    dec0 = vld0 ? (1 << idx0) : 0;
    dec1 = vld1 ? (1 << idx1) : 0;
    chk("inv0_decode", int'(gnt0), dec0);
    chk("inv1_decode", int'(gnt1), dec1);
  endtask

  task automatic chk_model();
    chk("m0_gnt", int'(gnt0), m_gnt(0));
    chk("m0_idx", int'(idx0), m_own[0]);
    chk("m0_vld", int'(vld0), m_vld[0]);
    chk("m1_gnt", int'(gnt1), m_gnt(1));
    chk("m1_idx", int'(idx1), m_own[1]);
    chk("m1_vld", int'(vld1), m_vld[1]);
    chk_inv();
  endtask

  // Called from the falling edge; returns at the next falling edge.
  task automatic step(input logic [3:0] req);
    REQ = req;
    @(posedge CLK);
    mstep(req);
    #1;
    chk_model();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    REQ = 4'b0000;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    mreset();
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{4'b0010, 4'b0010, 2'd1, 1'b1};  // single request
    vecs[1]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};  // drop -> idle
    vecs[2]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[3]  = '{4'b0001, 4'b0001, 2'd0, 1'b1};  // owner 0, grant cycle 1
    vecs[4]  = '{4'b0101, 4'b0001, 2'd0, 1'b1};  // cycle 2, no pre-emption
    vecs[5]  = '{4'b0101, 4'b0001, 2'd0, 1'b1};  // cycle 3
    vecs[6]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};  // early release
    vecs[7]  = '{4'b1100, 4'b0100, 2'd2, 1'b1};  // non-owner change ignored
    vecs[8]  = '{4'b1000, 4'b1000, 2'd3, 1'b1};
    vecs[9]  = '{4'b1011, 4'b1000, 2'd3, 1'b1};
    vecs[10] = '{4'b0000, 4'b0000, 2'd0, 1'b0};

    // Reset state, including asynchronous behaviour before any edge
    #1;
    chk("rst_gnt", int'(gnt0), 0);
    chk("rst_vld", int'(vld0), 0);
    chk("rst_idx", int'(idx0), 0);
    do_reset();

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].req);
      chk($sformatf("vec%0d_gnt", i), int'(gnt0), int'(vecs[i].gnt));
      chk($sformatf("vec%0d_idx", i), int'(idx0), int'(vecs[i].idx));
      chk($sformatf("vec%0d_vld", i), int'(vld0), int'(vecs[i].vld));
    end

    // Fairness with all four requesting: 8-cycle turns (MAX_HOLD=8), every cycle (MAX_HOLD=1)
    do_reset();
    for (int s = 0; s < 40; s++) begin
      step(4'b1111);
      chk("fair8_gnt", int'(gnt0), 1 << ((s / 8) % 4));
      chk("fair1_gnt", int'(gnt1), 1 << (s % 4));
    end

    // Asynchronous reset mid-grant, then search restarts at requester 0
    #2;
    RST = 1'b1;
    #1;
    chk("arst_gnt", int'(gnt0), 0);
    chk("arst_vld", int'(vld0), 0);
    chk("arst_gnt1", int'(gnt1), 0);
    @(negedge CLK);
    RST = 1'b0;
    mreset();
    step(4'b1111);
    chk("post_rst_gnt", int'(gnt0), 4'b0001);

    // Sole requester keeps the grant through repeated hold limits
    do_reset();
    for (int s = 0; s < 20; s++) begin
      step(4'b1000);
      chk("sole_gnt0", int'(gnt0), 4'b1000);
      chk("sole_vld0", int'(vld0), 1);
      chk("sole_gnt1", int'(gnt1), 4'b1000);
    end

    // Randomized traffic, mostly holding the previous pattern
    do_reset();
    begin
      logic [3:0] r;
      r = 4'b0000;
      for (int s = 0; s < 400; s++) begin
        if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
        else if ($urandom_range(0, 3) == 0) r[$urandom_range(0, 3)] = ~r[$urandom_range(0, 3)];
        step(r);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
